// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, FSM encoding and default width for the ALU
//               request arbiter and its datapath core.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational AND/OR/ADD/SUB built from a chain of per-bit
//               full-adder slices; carry is carry-out for ADD, borrow for SUB.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic             w_sub;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;

    // SUB is a + ~b + 1; the inverted carry-out is the unsigned borrow
    assign w_sub  = (op == OP_SUB);
    assign w_c[0] = w_sub;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            logic w_b;
            assign w_b        = b[i] ^ w_sub;
            assign w_sum[i]   = a[i] ^ w_b ^ w_c[i];
            assign w_c[i + 1] = (a[i] & w_b) | (w_c[i] & (a[i] ^ w_b));
        end
    endgenerate

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                result = w_sum;
                carry  = w_c[WIDTH];
            end
            default: begin
                result = w_sum;
                carry  = ~w_c[WIDTH];
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_arbiter
// Description : Round-robin two-port front end that issues one ALU operation
//               at a time and holds the result until the consumer accepts it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_op0,
    input  logic [1:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_id
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prio;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic             w_winner;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;

    // Contention is settled by prio; a lone requester wins outright
    assign w_winner = (&req_valid) ? r_prio : req_valid[1];
    assign w_accept = (r_state == IDLE) && (|req_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    req_ready[w_winner] = 1'b1;
                    w_state_nxt         = EXEC;
                end
            end
            EXEC:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op     (r_op),
        .a      (r_a),
        .b      (r_b),
        .result (w_result),
        .carry  (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio     <= 1'b0;
            r_op       <= OP_AND;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= w_winner ? req_op1 : req_op0;
                r_a    <= w_winner ? req_a1  : req_a0;
                r_b    <= w_winner ? req_b1  : req_b0;
                r_id   <= w_winner;
                r_prio <= ~w_winner;
            end
            if (r_state == EXEC) begin
                rsp_result <= w_result;
                rsp_carry  <= w_carry;
                rsp_zero   <= (w_result == '0);
                rsp_id     <= r_id;
                rsp_valid  <= 1'b1;
            end else if ((r_state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_req_arbiter
// Description : Directed self-checking bench with a response scoreboard and a
//               cycle-level reference of the grant/response protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_req_arbiter;

    localparam int C_W = 4;

    typedef struct packed {
        logic           id;
        logic           carry;
        logic           zero;
        logic [C_W-1:0] result;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [1:0]     req_op0;
    logic [1:0]     req_op1;
    logic [C_W-1:0] req_a0;
    logic [C_W-1:0] req_b0;
    logic [C_W-1:0] req_a1;
    logic [C_W-1:0] req_b1;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [C_W-1:0] rsp_result;
    logic           rsp_carry;
    logic           rsp_zero;
    logic           rsp_id;

    int   n_vec;
    int   n_err;
    exp_t sb[$];
    int   m_state;   // 0 idle, 1 exec, 2 resp
    logic m_prio;

    alu_req_arbiter #(.WIDTH(C_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [C_W:0] alu_model(input logic [1:0] op,
                                               input logic [C_W-1:0] a,
                                               input logic [C_W-1:0] b);
        case (op)
            2'b00:   return {1'b0, a & b};
            2'b01:   return {1'b0, a | b};
            2'b10:   return {1'b0, a} + {1'b0, b};
            default: return {(a < b), a - b};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_state = 0;
        m_prio  = 1'b0;
    endtask

    // One clock: check protocol and scoreboard before the edge, advance the model, step
    task automatic cycle();
        logic [1:0]     exp_ready;
        logic           w;
        logic [C_W:0]   r;
        exp_t           e;
        #1;
        exp_ready = 2'b00;
        w = 1'b0;
        if (m_state == 0 && req_valid != 2'b00) begin
            w = (req_valid == 2'b11) ? m_prio : req_valid[1];
            exp_ready[w] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_state == 2));
        if (m_state == 2) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(1), 32'(0));
            end else begin
                check("rsp_result", 32'(rsp_result), 32'(sb[0].result));
                check("rsp_carry",  32'(rsp_carry),  32'(sb[0].carry));
                check("rsp_zero",   32'(rsp_zero),   32'(sb[0].zero));
                check("rsp_id",     32'(rsp_id),     32'(sb[0].id));
            end
        end
        if (m_state == 0 && req_valid != 2'b00) begin
            r = w ? alu_model(req_op1, req_a1, req_b1) : alu_model(req_op0, req_a0, req_b0);
            e.id     = w;
            e.carry  = r[C_W];
            e.result = r[C_W-1:0];
            e.zero   = (r[C_W-1:0] == '0);
            sb.push_back(e);
            m_prio  = ~w;
            m_state = 1;
        end else if (m_state == 1) begin
            m_state = 2;
        end else if (m_state == 2 && rsp_ready) begin
            if (sb.size() > 0) void'(sb.pop_front());
            m_state = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_op0 = 2'b00; req_op1 = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        rsp_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  32'(req_ready),  32'(0));
        check("rst_rsp_valid",  32'(rsp_valid),  32'(0));
        check("rst_rsp_result", 32'(rsp_result), 32'(0));
        check("rst_rsp_carry",  32'(rsp_carry),  32'(0));
        check("rst_rsp_zero",   32'(rsp_zero),   32'(0));
        check("rst_rsp_id",     32'(rsp_id),     32'(0));
        rst_n = 1'b1;
        repeat (2) cycle();

        // Requester 0 alone: AND C & A
        req_valid = 2'b01; req_op0 = 2'b00; req_a0 = 4'hC; req_b0 = 4'hA;
        cycle();
        req_valid = 2'b00;
        cycle();
        check("and_result", 32'(rsp_result), 32'(4'h8));
        cycle();

        // Requester 1 alone: ADD F + 1, then SUB 3 - 5
        req_valid = 2'b10; req_op1 = 2'b10; req_a1 = 4'hF; req_b1 = 4'h1;
        cycle();
        req_valid = 2'b00;
        cycle();
        check("add_zero", 32'(rsp_zero), 32'(1));
        cycle();
        req_valid = 2'b10; req_op1 = 2'b11; req_a1 = 4'h3; req_b1 = 4'h5;
        cycle();
        req_valid = 2'b00;
        cycle();
        check("sub_result", 32'(rsp_result), 32'(4'hE));
        cycle();

        // Both contending from reset prio: strict alternation, 3 cycles per op
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 2'b11;
        req_op0 = 2'b10; req_a0 = 4'h1; req_b0 = 4'h2;
        req_op1 = 2'b11; req_a1 = 4'h7; req_b1 = 4'h9;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_grant", 32'(req_ready), (i % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
            repeat (3) cycle();
        end
        req_valid = 2'b00;
        cycle();

        // Backpressure: held response, no grants while blocked
        req_valid = 2'b11; rsp_ready = 1'b0;
        req_op0 = 2'b00; req_a0 = 4'h6; req_b0 = 4'h3;
        cycle();
        cycle();
        repeat (5) cycle();
        rsp_ready = 1'b1;
        cycle();
        req_valid = 2'b00;
        repeat (3) cycle();
        req_valid = 2'b10;
        repeat (3) cycle();
        req_valid = 2'b00;
        cycle();

        // OR 0|0 -> zero; a request arriving during EXEC waits for IDLE
        req_valid = 2'b01; req_op0 = 2'b01; req_a0 = 4'h0; req_b0 = 4'h0;
        cycle();
        req_valid = 2'b10; req_op1 = 2'b00; req_a1 = 4'h5; req_b1 = 4'h7;
        cycle();
        check("or_zero", 32'(rsp_zero), 32'(1));
        cycle();
        check("late_grant", 32'(req_ready), 32'(2'b10));
        cycle();
        req_valid = 2'b00;
        repeat (3) cycle();

        // Reset asserted during RESP discards the pending response
        req_valid = 2'b01; rsp_ready = 1'b0;
        req_op0 = 2'b10; req_a0 = 4'h4; req_b0 = 4'h4;
        cycle();
        req_valid = 2'b00;
        cycle();
        check("pre_rst_valid", 32'(rsp_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",  32'(rsp_valid),  32'(0));
        check("async_rst_result", 32'(rsp_result), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
